lamp_conflict_monitor: RTL and testbench
========================================

# lamp_conflict_monitor

Safety stage directly downstream of the traffic-light state machine: it samples the controller's red/yellow/green aspect outputs, checks them for illegal lamp combinations and illegal aspect sequences, and drives the physical lamp outputs. On a detected fault it latches a fault code and forces the intersection into flashing red until an operator clear is accepted. In normal operation the lamp drive is a registered copy of the controller outputs.

## Interface
- FILT_CYCLES, default 3: consecutive illegal-pattern cycles required before a pattern fault latches (≥1).
- FLASH_HALF, default 4: cycles red stays on, and cycles red stays off, per flash period in FAULT (≥1).
- MIN_YELLOW, default 1: minimum consecutive yellow cycles before a Y→R transition; used only with the dwell feature.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- red  in  1  controller red aspect.
- yellow  in  1  controller yellow aspect.
- green  in  1  controller green aspect.
- fault_clr  in  1  operator clear request, single-cycle sampled.
- lamp_red  out  1  red lamp drive.
- lamp_yellow  out  1  yellow lamp drive.
- lamp_green  out  1  green lamp drive.
- fault  out  1  latched fault indicator.
- fault_code  out  2  00 none, 01 illegal pattern, 10 illegal sequence, 11 yellow dwell violation.

## Operation
- Legal pattern: exactly one of red/yellow/green high. Anything else (none, two, three) is illegal.
- Internal last_aspect register (RED/GREEN/YELLOW) holds the last legal aspect sampled.
- States: NORMAL, FILTER, FAULT.
- NORMAL, legal input: lamps ← input; last_aspect updated. Allowed transitions: same aspect, R→G, G→Y, Y→R. Any other legal-to-legal change (R→Y, G→R, Y→G) → FAULT, code 10.
- NORMAL, illegal input: → FILTER, illegal counter = 1; lamps hold last_aspect. If FILT_CYCLES = 1 go straight to FAULT, code 01.
- FILTER: illegal input increments counter; counter reaching FILT_CYCLES → FAULT, code 01. Legal input clears counter, returns to NORMAL and is sequence-checked against last_aspect exactly as in NORMAL.
- FAULT: lamp_yellow = lamp_green = 0; lamp_red on for FLASH_HALF cycles, off for FLASH_HALF cycles, repeating, starting on in the first FAULT cycle. Input checks suspended; fault_code frozen.
- fault_clr in FAULT accepted only if the sampled input is exactly red (1,0,0): → NORMAL, fault = 0, fault_code = 00, last_aspect = RED, counters cleared, lamp_red steady 1. Otherwise ignored. fault_clr ignored in NORMAL/FILTER.
- Flash counter and yellow counter saturate; no wrap-induced behaviour.

## Timing
- Reset values: lamp_red 1, lamp_yellow 0, lamp_green 0, fault 0, fault_code 00; state NORMAL, last_aspect RED, all counters 0. Reset is asynchronous and takes effect mid-fault or mid-flash immediately.
- Latency: input sampled at edge n appears on lamps after edge n; fault and fault_code assert after the same edge that samples the offending input; flashing red begins at that edge.
- Pattern fault: illegal on FILT_CYCLES consecutive sampling edges → fault after the last of them. FILT_CYCLES−1 illegal cycles followed by legal → no fault.
- Clear: fault_clr with red input sampled at edge n → lamps steady red, fault 0 after edge n.

## Configuration
- LAMP_MON_DWELL_EN defined: yellow counter counts consecutive yellow samples; a Y→R transition with count < MIN_YELLOW → FAULT, code 11.
- Undefined: no yellow counter, code 11 never produced, MIN_YELLOW ignored.

## Structure
- Shared package traffic_pkg: aspect encoding RED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10 (same as the controller), monitor state enum, fault code constants.
- One sub-module: lamp_flasher (enable, FLASH_HALF parameter, flash output; restarts "on" when enabled).

## Test plan
- Reset, then drive R,G,Y,R one per cycle → lamps follow one cycle later, fault 0, fault_code 00.
- FILT_CYCLES=3: red+green for 2 cycles then red → no fault, lamps hold last aspect; red+green for 3 cycles → fault 1, code 01, lamp_red 1111 0000 1111 with FLASH_HALF=4.
- Green followed directly by red → fault after that edge, code 10, lamp_green 0.
- In FAULT, fault_clr with input green → ignored; fault_clr with input red → fault 0, code 00, lamp_red steady 1 next cycle.
- LAMP_MON_DWELL_EN with MIN_YELLOW=2: yellow 1 cycle then red → code 11; yellow 2 cycles then red → no fault; macro undefined → no fault either way.
- Assert reset during a flash-off phase → lamp_red 1, fault 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light datapath.
//
// Contents:
//   aspect_t         aspect encoding shared with the controller
//                    (RED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10)
//   mon_state_t      lamp conflict monitor state encoding (NORMAL/FILTER/FAULT)
//   FC_*             fault code constants reported on fault_code
//   seq_allowed()    legal aspect-to-aspect step check
//   aspect_lamps()   aspect to {red, yellow, green} lamp drive
package traffic_pkg;

    typedef enum logic [1:0] {
        ASPECT_RED    = 2'b00,
        ASPECT_GREEN  = 2'b01,
        ASPECT_YELLOW = 2'b10
    } aspect_t;

    typedef logic [1:0] mon_state_t;

    localparam mon_state_t ST_NORMAL = 2'd0;
    localparam mon_state_t ST_FILTER = 2'd1;
    localparam mon_state_t ST_FAULT  = 2'd2;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_PATTERN  = 2'b01;
    localparam logic [1:0] FC_SEQUENCE = 2'b10;
    localparam logic [1:0] FC_DWELL    = 2'b11;

    // Holding the same aspect is always fine; otherwise only the normal
    // cycle R -> G -> Y -> R is permitted.
    function automatic logic seq_allowed(input aspect_t from_a, input aspect_t to_a);
        logic ok;
        ok = (from_a == to_a);
        case (from_a)
            ASPECT_RED:    if (to_a == ASPECT_GREEN)  ok = 1'b1;
            ASPECT_GREEN:  if (to_a == ASPECT_YELLOW) ok = 1'b1;
            ASPECT_YELLOW: if (to_a == ASPECT_RED)    ok = 1'b1;
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Returns {red, yellow, green}. The unused encoding falls back to red
    // so a corrupted aspect can never light green.
    function automatic logic [2:0] aspect_lamps(input aspect_t a);
        logic [2:0] lamps;
        case (a)
            ASPECT_GREEN:  lamps = 3'b001;
            ASPECT_YELLOW: lamps = 3'b010;
            default:       lamps = 3'b100;
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/lamp_flasher.sv
// Flashing-red generator used while the monitor is in FAULT.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous, active-high
//   enable  in   flashing requested
//   flash   out  red drive: on for FLASH_HALF cycles, off for FLASH_HALF
//                cycles, repeating; always starts "on" in the first enabled
//                cycle; low whenever enable is low.
//
// Parameters:
//   FLASH_HALF  length of each on/off half period in cycles (>= 1)
module lamp_flasher #(
    parameter int FLASH_HALF = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic flash
);

    localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(FLASH_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          on_q, on_d;

    // While disabled the generator sits at the start of an "on" half so the
    // first enabled cycle is lit. The counter never exceeds LAST.
    always_comb begin
        cnt_d = cnt_q;
        on_d  = on_q;
        if (!enable) begin
            cnt_d = '0;
            on_d  = 1'b1;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            on_d  = ~on_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            on_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            on_q  <= on_d;
        end
    end

    assign flash = enable & on_q;

endmodule

// File: rtl/lamp_conflict_monitor.sv
// Safety stage between the traffic-light controller and the lamp drivers.
// Checks the controller aspects for illegal lamp combinations (filtered over
// FILT_CYCLES samples) and illegal aspect sequences, drives the lamps from a
// registered copy of the controller outputs, and on a fault latches a fault
// code and flashes red until an operator clear with a red input is accepted.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high
//   red          in   controller red aspect
//   yellow       in   controller yellow aspect
//   green        in   controller green aspect
//   fault_clr    in   operator clear request (sampled each cycle)
//   lamp_red     out  red lamp drive
//   lamp_yellow  out  yellow lamp drive
//   lamp_green   out  green lamp drive
//   fault        out  latched fault indicator
//   fault_code   out  00 none, 01 illegal pattern, 10 illegal sequence,
//                     11 yellow dwell violation
//
// Parameters:
//   FILT_CYCLES  consecutive illegal samples before a pattern fault (>= 1)
//   FLASH_HALF   flash half period in cycles (>= 1)
//   MIN_YELLOW   minimum consecutive yellow samples before Y -> R
//
// Build option:
//   LAMP_MON_DWELL_EN  when defined, enables the yellow dwell check
//                      (fault code 11). When undefined MIN_YELLOW is ignored.
module lamp_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int FILT_CYCLES = 3,
    parameter int FLASH_HALF  = 4,
    parameter int MIN_YELLOW  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic       fault_clr,
    output logic       lamp_red,
    output logic       lamp_yellow,
    output logic       lamp_green,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int FW = $clog2(FILT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILT_CYCLES);

    mon_state_t    state_q, state_d;
    aspect_t       last_q, last_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [1:0]    code_q, code_d;
    logic [2:0]    lamps_q, lamps_d;   // {red, yellow, green}

    logic [2:0]    in_pat;
    logic          in_legal;
    aspect_t       in_aspect;
    logic          clr_accept;
    logic          dwell_short;
    logic          flash_on;

    assign in_pat = {red, yellow, green};

    always_comb begin
        in_legal  = 1'b1;
        in_aspect = ASPECT_RED;
        case (in_pat)
            3'b100:  in_aspect = ASPECT_RED;
            3'b010:  in_aspect = ASPECT_YELLOW;
            3'b001:  in_aspect = ASPECT_GREEN;
            default: in_legal  = 1'b0;
        endcase
    end

    // A clear is only honoured while the controller is already showing
    // plain red, so leaving FAULT never exposes a conflicting aspect.
    assign clr_accept = (state_q == ST_FAULT) && fault_clr && (in_pat == 3'b100);

`ifdef LAMP_MON_DWELL_EN
    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam logic [YW-1:0] YEL_MAX = YW'(MIN_YELLOW);

    logic [YW-1:0] ycnt_q, ycnt_d;

    // Counts consecutive legal yellow samples, saturating at MIN_YELLOW
    // (enough to decide the check). Filtered illegal samples hold the count
    // so a brief glitch inside a yellow phase does not shorten it.
    always_comb begin
        ycnt_d = ycnt_q;
        if (state_q == ST_FAULT) begin
            if (clr_accept) ycnt_d = '0;
        end else if (in_legal) begin
            if (in_aspect == ASPECT_YELLOW) begin
                if (last_q != ASPECT_YELLOW) ycnt_d = YW'(1);
                else if (ycnt_q != YEL_MAX)  ycnt_d = ycnt_q + YW'(1);
            end else begin
                ycnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ycnt_q <= '0;
        else       ycnt_q <= ycnt_d;
    end

    assign dwell_short = (last_q == ASPECT_YELLOW) && (in_aspect == ASPECT_RED)
                         && (ycnt_q < YEL_MAX);
`else
    logic min_yellow_unused;
    assign min_yellow_unused = (MIN_YELLOW != 0);
    assign dwell_short       = 1'b0;
`endif

    logic          fault_hit;
    logic [1:0]    fault_cause;
    logic [FW-1:0] filt_inc;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        filt_cnt_d  = filt_cnt_q;
        code_d      = code_q;
        lamps_d     = lamps_q;
        fault_hit   = 1'b0;
        fault_cause = FC_NONE;
        filt_inc    = (filt_cnt_q == FILT_MAX) ? filt_cnt_q : filt_cnt_q + FW'(1);

        case (state_q)
            ST_NORMAL, ST_FILTER: begin
                if (in_legal) begin
                    // A legal sample ends any filtering run and is checked
                    // against the last legal aspect, even across the run.
                    state_d    = ST_NORMAL;
                    filt_cnt_d = '0;
                    if (!seq_allowed(last_q, in_aspect)) begin
                        fault_hit   = 1'b1;
                        fault_cause = FC_SEQUENCE;
                    end else if (dwell_short) begin
                        fault_hit   = 1'b1;
                        fault_cause = FC_DWELL;
                    end else begin
                        lamps_d = aspect_lamps(in_aspect);
                        last_d  = in_aspect;
                    end
                end else begin
                    state_d    = ST_FILTER;
                    filt_cnt_d = filt_inc;
                    lamps_d    = aspect_lamps(last_q);
                    if (filt_inc >= FILT_MAX) begin
                        fault_hit   = 1'b1;
                        fault_cause = FC_PATTERN;
                    end
                end
            end
            ST_FAULT: begin
                if (clr_accept) begin
                    state_d    = ST_NORMAL;
                    code_d     = FC_NONE;
                    last_d     = ASPECT_RED;
                    filt_cnt_d = '0;
                    lamps_d    = 3'b100;
                end
            end
            default: begin
                // Unreachable encoding: fail safe into a sequence-style fault.
                fault_hit   = 1'b1;
                fault_cause = FC_SEQUENCE;
            end
        endcase

        if (fault_hit) begin
            state_d    = ST_FAULT;
            code_d     = fault_cause;
            filt_cnt_d = '0;
            lamps_d    = 3'b100;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_NORMAL;
            last_q     <= ASPECT_RED;
            filt_cnt_q <= '0;
            code_q     <= FC_NONE;
            lamps_q    <= 3'b100;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            filt_cnt_q <= filt_cnt_d;
            code_q     <= code_d;
            lamps_q    <= lamps_d;
        end
    end

    lamp_flasher #(
        .FLASH_HALF(FLASH_HALF)
    ) u_flasher (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q == ST_FAULT),
        .flash  (flash_on)
    );

    // Fault is decoded straight from the state flop so an asynchronous reset
    // drops it, and restores steady red, without waiting for a clock.
    assign fault       = (state_q == ST_FAULT);
    assign lamp_red    = fault ? flash_on : lamps_q[2];
    assign lamp_yellow = lamps_q[1] & ~fault;
    assign lamp_green  = lamps_q[0] & ~fault;
    assign fault_code  = code_q;

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Directed bench for lamp_conflict_monitor with FILT_CYCLES=3, FLASH_HALF=4,
// MIN_YELLOW=2. Observed vector is {lamp_red, lamp_yellow, lamp_green,
// fault, fault_code[1:0]}.
module tb_lamp_conflict_monitor;

    localparam int FILT_CYCLES = 3;
    localparam int FLASH_HALF  = 4;
    localparam int MIN_YELLOW  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       red = 1'b1;
    logic       yellow = 1'b0;
    logic       green = 1'b0;
    logic       fault_clr = 1'b0;
    logic       lamp_red, lamp_yellow, lamp_green, fault;
    logic [1:0] fault_code;

    int checks = 0;
    int failures = 0;

    lamp_conflict_monitor #(
        .FILT_CYCLES(FILT_CYCLES),
        .FLASH_HALF (FLASH_HALF),
        .MIN_YELLOW (MIN_YELLOW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .fault_clr  (fault_clr),
        .lamp_red   (lamp_red),
        .lamp_yellow(lamp_yellow),
        .lamp_green (lamp_green),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    // Expected vectors
    localparam logic [5:0] V_RED   = 6'b100_0_00;
    localparam logic [5:0] V_YEL   = 6'b010_0_00;
    localparam logic [5:0] V_GRN   = 6'b001_0_00;

    function automatic logic [5:0] obs_vec();
        return {lamp_red, lamp_yellow, lamp_green, fault, fault_code};
    endfunction

    // Expected output k cycles into a fault with the given code.
    function automatic logic [5:0] fault_vec(input int k, input logic [1:0] code);
        logic on;
        on = ((k / FLASH_HALF) % 2) == 0;
        return {on, 2'b00, 1'b1, code};
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one sample, let it be taken at the next rising edge, then settle.
    task automatic step(input logic r, input logic y, input logic g, input logic clr);
        red = r; yellow = y; green = g; fault_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        #2 reset = 1'b1;
        #2 check("reset_async", obs_vec(), V_RED);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        check("reset_state", obs_vec(), V_RED);

        // Normal cycle; yellow held two samples so the dwell build is happy.
        step(1, 0, 0, 0); check("seq_r", obs_vec(), V_RED);
        red = 1'b0; green = 1'b1; #2;
        check("latency_hold", obs_vec(), V_RED);
        step(0, 0, 1, 0); check("seq_g", obs_vec(), V_GRN);
        step(0, 1, 0, 0); check("seq_y1", obs_vec(), V_YEL);
        step(0, 1, 0, 0); check("seq_y2", obs_vec(), V_YEL);
        step(1, 0, 0, 0); check("seq_r2", obs_vec(), V_RED);

        // FILT_CYCLES-1 illegal then legal: no fault, lamps hold red.
        step(1, 0, 1, 0); check("filt_r_1", obs_vec(), V_RED);
        step(1, 0, 1, 0); check("filt_r_2", obs_vec(), V_RED);
        step(1, 0, 0, 0); check("filt_r_exit", obs_vec(), V_RED);

        // Same while last aspect is green: lamps hold green.
        step(0, 0, 1, 0); check("filt_g_pre", obs_vec(), V_GRN);
        step(1, 0, 1, 0); check("filt_g_1", obs_vec(), V_GRN);
        step(0, 0, 0, 0); check("filt_g_2", obs_vec(), V_GRN);
        step(0, 0, 1, 0); check("filt_g_exit", obs_vec(), V_GRN);

        // Three illegal samples: pattern fault then flashing red 1111 0000 1111.
        step(1, 0, 1, 0); check("pat_1", obs_vec(), V_GRN);
        step(1, 1, 1, 0); check("pat_2", obs_vec(), V_GRN);
        step(1, 0, 1, 0); check("pat_fault", obs_vec(), fault_vec(0, 2'b01));
        for (int k = 1; k < 12; k++) begin
            step(0, 0, 0, 0);
            check($sformatf("flash_k%0d", k), obs_vec(), fault_vec(k, 2'b01));
        end

        // Clear with green input is ignored; clear with red is accepted.
        step(0, 0, 1, 1); check("clr_green_ignored", obs_vec(), fault_vec(12, 2'b01));
        step(1, 0, 0, 1); check("clr_red", obs_vec(), V_RED);
        step(1, 0, 0, 0); check("after_clr_steady", obs_vec(), V_RED);

        // Green directly to red: sequence fault, green lamp off.
        step(0, 0, 1, 0); check("gr_pre", obs_vec(), V_GRN);
        step(1, 0, 0, 0); check("gr_fault", obs_vec(), fault_vec(0, 2'b10));
        step(1, 0, 0, 1); check("gr_clr", obs_vec(), V_RED);

        // Red directly to yellow: sequence fault.
        step(0, 1, 0, 0); check("ry_fault", obs_vec(), fault_vec(0, 2'b10));
        step(1, 0, 0, 0); check("ry_hold", obs_vec(), fault_vec(1, 2'b10));
        step(1, 0, 0, 1); check("ry_clr", obs_vec(), V_RED);

        // Yellow for one sample then red.
        step(0, 0, 1, 0); check("dw1_g", obs_vec(), V_GRN);
        step(0, 1, 0, 0); check("dw1_y", obs_vec(), V_YEL);
        step(1, 0, 0, 0);
`ifdef LAMP_MON_DWELL_EN
        check("dw1_r", obs_vec(), fault_vec(0, 2'b11));
        step(1, 0, 0, 1); check("dw1_clr", obs_vec(), V_RED);
`else
        check("dw1_r", obs_vec(), V_RED);
`endif

        // Yellow for two samples then red: legal in both builds.
        step(0, 0, 1, 0); check("dw2_g", obs_vec(), V_GRN);
        step(0, 1, 0, 0); check("dw2_y1", obs_vec(), V_YEL);
        step(0, 1, 0, 0); check("dw2_y2", obs_vec(), V_YEL);
        step(1, 0, 0, 0); check("dw2_r", obs_vec(), V_RED);

        // Clear outside FAULT has no effect.
        step(0, 0, 1, 1); check("clr_in_normal", obs_vec(), V_GRN);

        // Reset while the flasher is in its off phase.
        step(1, 0, 0, 0); check("rst_fault", obs_vec(), fault_vec(0, 2'b10));
        for (int k = 1; k <= FLASH_HALF; k++) begin
            step(1, 0, 0, 0);
        end
        check("rst_flash_off", obs_vec(), fault_vec(FLASH_HALF, 2'b10));
        #2 reset = 1'b1;
        #1 check("rst_mid_flash", obs_vec(), V_RED);
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_release", obs_vec(), V_RED);
        step(0, 0, 1, 0); check("post_rst_g", obs_vec(), V_GRN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
